// File: rtl/wts_arb_pkg.sv
// rtl/wts_arb_pkg.sv - shared types and parameter defaults for the wave RAM arbiter
package wts_arb_pkg;

  localparam int MEM_LATENCY_DEF   = 4;
  localparam int ADR_W_DEF         = 21;
  localparam int SND_BURST_MAX_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_SND = 1'b1
  } gnt_id_t;

endpackage

// File: rtl/wts_arb_latency_counter.sv
// rtl/wts_arb_latency_counter.sv - loadable 4-bit down counter, expired while at zero
module wts_arb_latency_counter (
  input  logic       clk,
  input  logic       nreset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       expired
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign expired = (count == 4'd0);

endmodule

// File: rtl/wts_ram_arbiter.sv
// rtl/wts_ram_arbiter.sv - shares the wave RAM port between CPU and sound sample fetch
// Define WTS_ARB_ROUND_ROBIN_EN to alternate ties instead of fixed priority with a burst limit.
module wts_ram_arbiter
  import wts_arb_pkg::*;
#(
  parameter int MEM_LATENCY   = MEM_LATENCY_DEF,
  parameter int ADR_W         = ADR_W_DEF,
  parameter int SND_BURST_MAX = SND_BURST_MAX_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cpu_req,
  input  logic             cpu_wrt,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [7:0]       cpu_dbo,
  output logic             cpu_ack,
  output logic [7:0]       cpu_dbi,
  input  logic             snd_req,
  input  logic [ADR_W-1:0] snd_adr,
  output logic             snd_ack,
  output logic [7:0]       snd_q,
  output logic             ramreq,
  output logic             ramwrt,
  output logic [ADR_W-1:0] ramadr,
  output logic [7:0]       ramdbo,
  input  logic [7:0]       ramdbi
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  arb_state_t state;
  arb_state_t state_next;
  gnt_id_t    gnt_id;
  gnt_id_t    win_id;
  logic       expired;
  logic       any_req;
  logic       tie_to_snd;
  logic       grant;
  logic       capture;
  logic       cnt_load;

  wts_arb_latency_counter u_lat (
    .clk        (clk),
    .nreset     (nreset),
    .load       (cnt_load),
    .load_value (LAT_LOAD),
    .expired    (expired)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_req || snd_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    any_req  = cpu_req | snd_req;
    grant    = (state == IDLE) && any_req;
    cnt_load = (state == ISSUE);
    capture  = (state == WAIT) && expired;
    win_id   = (snd_req && (!cpu_req || tie_to_snd)) ? GNT_SND : GNT_CPU;
  end

`ifdef WTS_ARB_ROUND_ROBIN_EN
  gnt_id_t last_grant;

  assign tie_to_snd = (last_grant == GNT_CPU);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_grant <= GNT_CPU;
    end else if (grant) begin
      last_grant <= win_id;
    end
  end
`else
  localparam logic [2:0] BURST_MAX = 3'(SND_BURST_MAX);

  logic [2:0] snd_streak;

  assign tie_to_snd = (snd_streak != BURST_MAX);

  // Streak only grows while the CPU is actually being held off.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      snd_streak <= 3'd0;
    end else if (grant) begin
      if (win_id == GNT_SND && cpu_req) begin
        if (snd_streak != BURST_MAX) snd_streak <= snd_streak + 3'd1;
      end else begin
        snd_streak <= 3'd0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      gnt_id  <= GNT_CPU;
      ramreq  <= 1'b0;
      ramwrt  <= 1'b0;
      ramadr  <= '0;
      ramdbo  <= 8'd0;
      cpu_ack <= 1'b0;
      snd_ack <= 1'b0;
      cpu_dbi <= 8'd0;
      snd_q   <= 8'd0;
    end else begin
      ramreq  <= grant;
      cpu_ack <= capture && (gnt_id == GNT_CPU);
      snd_ack <= capture && (gnt_id == GNT_SND);
      if (grant) begin
        gnt_id <= win_id;
        if (win_id == GNT_SND) begin
          ramadr <= snd_adr;
          ramwrt <= 1'b0;
        end else begin
          ramadr <= cpu_adr;
          ramwrt <= cpu_wrt;
          ramdbo <= cpu_dbo;
        end
      end
      // ramwrt still reflects the in-flight access, so writes leave cpu_dbi alone.
      if (capture && gnt_id == GNT_CPU && !ramwrt) cpu_dbi <= ramdbi;
      if (capture && gnt_id == GNT_SND) snd_q <= ramdbi;
    end
  end

endmodule

// File: tb/tb_wts_ram_arbiter.sv
// tb/tb_wts_ram_arbiter.sv - self-checking bench for wts_ram_arbiter
module tb_wts_ram_arbiter;

  localparam int LAT = 4;

  typedef struct {
    logic        is_snd;
    logic        wrt;
    logic [20:0] adr;
    logic [7:0]  dbo;
    logic [7:0]  exp;
    int          issue;
  } txn_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wrt = 1'b0;
  logic [20:0] cpu_adr = '0;
  logic [7:0]  cpu_dbo = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_dbi;
  logic        snd_req = 1'b0;
  logic [20:0] snd_adr = '0;
  logic        snd_ack;
  logic [7:0]  snd_q;
  logic        ramreq;
  logic        ramwrt;
  logic [20:0] ramadr;
  logic [7:0]  ramdbo;
  logic [7:0]  ramdbi;

  logic        snd_req1 = 1'b0;
  logic [20:0] snd_adr1 = '0;
  logic        cpu_ack1;
  logic [7:0]  cpu_dbi1;
  logic        snd_ack1;
  logic [7:0]  snd_q1;
  logic        ramreq1;
  logic        ramwrt1;
  logic [20:0] ramadr1;
  logic [7:0]  ramdbo1;
  logic [7:0]  ramdbi1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ack_count = 0;
  logic        ack_prev = 1'b0;
  logic [7:0]  model_dbo = 8'd0;
  txn_t        exp_q[$];
  txn_t        inflight[$];
  txn_t        it;

  logic [LAT-1:0] req_pipe = '0;
  logic [20:0]    adr_pipe [LAT];
  logic           req1_d = 1'b0;
  logic [20:0]    adr1_d = '0;

  wts_ram_arbiter dut (
    .clk(clk), .nreset(nreset),
    .cpu_req(cpu_req), .cpu_wrt(cpu_wrt), .cpu_adr(cpu_adr), .cpu_dbo(cpu_dbo),
    .cpu_ack(cpu_ack), .cpu_dbi(cpu_dbi),
    .snd_req(snd_req), .snd_adr(snd_adr), .snd_ack(snd_ack), .snd_q(snd_q),
    .ramreq(ramreq), .ramwrt(ramwrt), .ramadr(ramadr), .ramdbo(ramdbo), .ramdbi(ramdbi)
  );

  wts_ram_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .nreset(nreset),
    .cpu_req(1'b0), .cpu_wrt(1'b0), .cpu_adr(21'h0), .cpu_dbo(8'h00),
    .cpu_ack(cpu_ack1), .cpu_dbi(cpu_dbi1),
    .snd_req(snd_req1), .snd_adr(snd_adr1), .snd_ack(snd_ack1), .snd_q(snd_q1),
    .ramreq(ramreq1), .ramwrt(ramwrt1), .ramadr(ramadr1), .ramdbo(ramdbo1), .ramdbi(ramdbi1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input logic [20:0] a);
    if (a == 21'h01234) return 8'hA5;
    if (a == 21'h00777) return 8'h7F;
    return a[7:0] ^ 8'hC3;
  endfunction

  // RAM model: data is only valid in the cycle exactly LAT cycles after ramreq.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    req_pipe <= {req_pipe[LAT-2:0], ramreq};
    adr_pipe[0] <= ramadr;
    for (int i = 1; i < LAT; i++) adr_pipe[i] <= adr_pipe[i-1];
    req1_d <= ramreq1;
    adr1_d <= ramadr1;
  end

  assign ramdbi  = req_pipe[LAT-1] ? ram_val(adr_pipe[LAT-1]) : 8'hEE;
  assign ramdbi1 = req1_d ? ram_val(adr1_d) : 8'hEE;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: grants pop the expected queue, acks pop the in-flight queue.
  always @(negedge clk) begin
    if (nreset) begin
      if (ramreq) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ramreq: adr %0h at cycle %0d", ramadr, cyc);
        end else begin
          it = exp_q.pop_front();
          check("grant_adr", 32'(ramadr), 32'(it.adr));
          check("grant_wrt", 32'(ramwrt), 32'(it.wrt));
          if (it.is_snd) begin
            check("snd_dbo_hold", 32'(ramdbo), 32'(model_dbo));
          end else begin
            if (it.wrt) check("wr_dbo", 32'(ramdbo), 32'(it.dbo));
            model_dbo = it.dbo;
          end
          it.issue = cyc;
          inflight.push_back(it);
        end
      end
      if (cpu_ack || snd_ack) begin
        ack_count++;
        check("ack_width", 32'(ack_prev), 32'(0));
        if (inflight.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: cpu %0b snd %0b at cycle %0d", cpu_ack, snd_ack, cyc);
        end else begin
          it = inflight.pop_front();
          check("ack_snd", 32'(snd_ack), 32'(it.is_snd));
          check("ack_cpu", 32'(cpu_ack), 32'(!it.is_snd));
          check("ack_latency", 32'(cyc - it.issue), 32'(LAT + 1));
          if (it.is_snd) check("snd_q", 32'(snd_q), 32'(it.exp));
          else           check("cpu_dbi", 32'(cpu_dbi), 32'(it.exp));
        end
      end
      ack_prev = cpu_ack | snd_ack;
    end
  end

  task automatic flush_model();
    exp_q.delete();
    inflight.delete();
    model_dbo = 8'd0;
    ack_prev  = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    cpu_req = 1'b0;
    snd_req = 1'b0;
    flush_model();
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_lone(input txn_t t);
    logic got;
    got = 1'b0;
    exp_q.push_back(t);
    if (t.is_snd) begin
      snd_adr = t.adr;
      snd_req = 1'b1;
    end else begin
      cpu_adr = t.adr;
      cpu_wrt = t.wrt;
      cpu_dbo = t.dbo;
      cpu_req = 1'b1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack || snd_ack) got = 1'b1;
    end
    cpu_req = 1'b0;
    snd_req = 1'b0;
    check("lone_ack_seen", 32'(got), 32'(1));
    @(negedge clk);
  endtask

  initial begin
    txn_t vecs [8];
    txn_t t;
    logic got;
    int   n;
    int   acks_before;
    int   c0;
    int   c1;

    vecs[0] = '{is_snd:1'b0, wrt:1'b0, adr:21'h01234,  dbo:8'h00, exp:8'hA5, issue:0};
    vecs[1] = '{is_snd:1'b0, wrt:1'b1, adr:21'h1FFFF,  dbo:8'h3C, exp:8'hA5, issue:0};
    vecs[2] = '{is_snd:1'b1, wrt:1'b0, adr:21'h00777,  dbo:8'h00, exp:8'h7F, issue:0};
    vecs[3] = '{is_snd:1'b1, wrt:1'b0, adr:21'h1ABCD,  dbo:8'h00, exp:8'h0E, issue:0};
    vecs[4] = '{is_snd:1'b0, wrt:1'b0, adr:21'h00000,  dbo:8'h00, exp:8'hC3, issue:0};
    vecs[5] = '{is_snd:1'b0, wrt:1'b1, adr:21'h1FFFFF, dbo:8'hFF, exp:8'hC3, issue:0};
    vecs[6] = '{is_snd:1'b0, wrt:1'b0, adr:21'h1FFFFF, dbo:8'h00, exp:8'h3C, issue:0};
    vecs[7] = '{is_snd:1'b1, wrt:1'b0, adr:21'h00010,  dbo:8'h00, exp:8'hD3, issue:0};

    repeat (3) @(negedge clk);
    check("rst_ramreq",  32'(ramreq),  32'(0));
    check("rst_ramwrt",  32'(ramwrt),  32'(0));
    check("rst_ramadr",  32'(ramadr),  32'(0));
    check("rst_ramdbo",  32'(ramdbo),  32'(0));
    check("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    check("rst_cpu_dbi", 32'(cpu_dbi), 32'(0));
    check("rst_snd_ack", 32'(snd_ack), 32'(0));
    check("rst_snd_q",   32'(snd_q),   32'(0));
    nreset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_lone(vecs[i]);

    // Both requesters held high from reset.
    do_reset();
    cpu_adr = 21'h0CAFE;
    cpu_wrt = 1'b0;
    cpu_dbo = 8'h00;
    snd_adr = 21'h1BEEF;
    for (int k = 0; k < 8; k++) begin
`ifdef WTS_ARB_ROUND_ROBIN_EN
      t.is_snd = (k % 2 == 0);
`else
      t.is_snd = (k % 4 != 3);
`endif
      t.wrt   = 1'b0;
      t.adr   = t.is_snd ? snd_adr : cpu_adr;
      t.dbo   = 8'h00;
      t.exp   = ram_val(t.adr);
      t.issue = 0;
      exp_q.push_back(t);
    end
    cpu_req = 1'b1;
    snd_req = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      @(negedge clk);
      if (cpu_ack || snd_ack) n++;
    end
    cpu_req = 1'b0;
    snd_req = 1'b0;
    check("tie_grants_done", 32'(n), 32'(8));
    repeat (2) @(negedge clk);

    // Reset while the access is waiting on RAM.
    t = '{is_snd:1'b0, wrt:1'b0, adr:21'h00ABC, dbo:8'h00, exp:8'h7F, issue:0};
    exp_q.push_back(t);
    cpu_adr = t.adr;
    cpu_wrt = 1'b0;
    cpu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ramreq) got = 1'b1;
    end
    check("rst_mid_issue", 32'(got), 32'(1));
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    #1;
    check("rst_mid_ramreq", 32'(ramreq), 32'(0));
    check("rst_mid_ack", 32'(cpu_ack | snd_ack), 32'(0));
    cpu_req = 1'b0;
    flush_model();
    acks_before = ack_count;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_no_ack", 32'(ack_count), 32'(acks_before));
    t = '{is_snd:1'b1, wrt:1'b0, adr:21'h00555, dbo:8'h00, exp:8'h96, issue:0};
    run_lone(t);

    // MEM_LATENCY=1 instance.
    snd_adr1 = 21'h00777;
    snd_req1 = 1'b1;
    got = 1'b0;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ramreq1) begin
        got = 1'b1;
        c0 = cyc;
      end
    end
    check("l1_issue", 32'(got), 32'(1));
    check("l1_adr", 32'(ramadr1), 32'(21'h00777));
    check("l1_wrt", 32'(ramwrt1), 32'(0));
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (snd_ack1) begin
        got = 1'b1;
        c1 = cyc;
      end
    end
    snd_req1 = 1'b0;
    check("l1_ack", 32'(got), 32'(1));
    check("l1_latency", 32'(c1 - c0), 32'(2));
    check("l1_snd_q", 32'(snd_q1), 32'(8'h7F));
    check("l1_cpu_ack", 32'(cpu_ack1), 32'(0));
    @(negedge clk);
    check("l1_ack_width", 32'(snd_ack1), 32'(0));
    check("l1_snd_q_hold", 32'(snd_q1), 32'(8'h7F));
    check("l1_ramdbo", 32'(ramdbo1), 32'(0));
    check("l1_cpu_dbi", 32'(cpu_dbi1), 32'(0));

    check("queues_drained", 32'(exp_q.size() + inflight.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d checks so far", checks);
    $fatal(1);
  end

endmodule
